// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: NUM_MASTERS masters share one slave port, ownership held for a whole CYC.
// Define WB_ARB_TIMEOUT_EN to add a stall watchdog that aborts the owner's cycle with a one-cycle error.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_n_i,
  input  logic [NUM_MASTERS*AW-1:0]     m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]     m_dat_i,
  input  logic [NUM_MASTERS*(DW/8)-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS-1:0]        m_cyc_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]      m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]      m_bte_i,
  output logic [DW-1:0]                 m_dat_o,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic [NUM_MASTERS-1:0]        m_rty_o,
  output logic [AW-1:0]                 s_adr_o,
  output logic [DW-1:0]                 s_dat_o,
  output logic [DW/8-1:0]               s_sel_o,
  output logic                          s_we_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  output logic [2:0]                    s_cti_o,
  output logic [1:0]                    s_bte_o,
  input  logic [DW-1:0]                 s_dat_i,
  input  logic                          s_ack_i,
  input  logic                          s_err_i,
  input  logic                          s_rty_i,
  output logic [NUM_MASTERS-1:0]        grant_o
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = DW / 8;
  localparam logic [IW:0] NM = (IW + 1)'(NUM_MASTERS);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("wb_rr_arbiter: NUM_MASTERS or TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1
`ifdef WB_ARB_TIMEOUT_EN
    , ABORT = 2'd2
`endif
  } state_e;

  state_e                 state_q;
  logic [IW-1:0]          owner_q;
  logic [IW-1:0]          last_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic                   abort_err;
  logic                   s_resp;
  logic                   req_found;
  logic [IW-1:0]          req_idx;
  logic [IW:0]            scan_idx;
  logic [31:0]            owner_w;

  assign s_resp  = s_ack_i | s_err_i | s_rty_i;
  assign owner_w = 32'(owner_q);
  assign grant_o = grant_q;

  // First requester strictly after the previous owner, wrapping modulo NUM_MASTERS.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    scan_idx  = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      scan_idx = {1'b0, last_q} + (IW + 1)'(i);
      if (scan_idx >= NM) scan_idx = scan_idx - NM;
      if (!req_found && m_cyc_i[scan_idx[IW-1:0]]) begin
        req_found = 1'b1;
        req_idx   = scan_idx[IW-1:0];
      end
    end
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    m_dat_o = '0;
    if (state_q == BUSY) begin
      s_adr_o = m_adr_i[owner_w*AW +: AW];
      s_dat_o = m_dat_i[owner_w*DW +: DW];
      s_sel_o = m_sel_i[owner_w*SW +: SW];
      s_we_o  = m_we_i[owner_q];
      s_cyc_o = m_cyc_i[owner_q];
      s_stb_o = m_stb_i[owner_q];
      s_cti_o = m_cti_i[owner_w*3 +: 3];
      s_bte_o = m_bte_i[owner_w*2 +: 2];
      m_dat_o = s_dat_i;
    end
  end

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_resp
    logic owned_busy;
    assign owned_busy  = (state_q == BUSY) && grant_q[gi];
    assign m_ack_o[gi] = owned_busy & s_ack_i;
    assign m_rty_o[gi] = owned_busy & s_rty_i;
    assign m_err_o[gi] = (owned_busy & s_err_i) | (abort_err & grant_q[gi]);
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] wdog_q;
  logic        abort_err_q;
  assign abort_err = abort_err_q;
`else
  assign abort_err = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      last_q      <= IW'(NUM_MASTERS - 1);
      grant_q     <= '0;
`ifdef WB_ARB_TIMEOUT_EN
      wdog_q      <= '0;
      abort_err_q <= 1'b0;
`endif
    end else begin
`ifdef WB_ARB_TIMEOUT_EN
      abort_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req_found) begin
            state_q <= BUSY;
            owner_q <= req_idx;
            grant_q <= NUM_MASTERS'(1) << req_idx;
`ifdef WB_ARB_TIMEOUT_EN
            wdog_q  <= '0;
`endif
          end
        end
        BUSY: begin
          if (!m_cyc_i[owner_q]) begin
            state_q <= IDLE;
            last_q  <= owner_q;
            grant_q <= '0;
          end
`ifdef WB_ARB_TIMEOUT_EN
          // A response arriving on the limit cycle still completes normally.
          else if (wdog_q >= WDOG_LIMIT && s_stb_o && !s_resp) begin
            state_q     <= ABORT;
            abort_err_q <= 1'b1;
          end else if (s_resp) begin
            wdog_q <= '0;
          end else if (s_stb_o) begin
            wdog_q <= wdog_q + 16'd1;
          end
        end
        ABORT: begin
          if (!m_cyc_i[owner_q]) begin
            state_q <= IDLE;
            last_q  <= owner_q;
            grant_q <= '0;
          end
`endif
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: cycle-by-cycle vector table plus reset and watchdog sequences.
module tb_wb_rr_arbiter;

  localparam int N = 3;
  localparam logic [2:0] NO = 3'b000;
  localparam logic [2:0] A  = 3'b001;
  localparam logic [2:0] E  = 3'b010;
  localparam logic [2:0] R  = 3'b100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [95:0]  m_adr;
  logic [95:0]  m_wdat;
  logic [11:0]  m_sel;
  logic [2:0]   m_we, m_cyc, m_stb;
  logic [8:0]   m_cti;
  logic [5:0]   m_bte;
  logic [2:0]   cti0;
  logic [31:0]  m_rdat;
  logic [2:0]   m_ack, m_err, m_rty;
  logic [31:0]  s_adr, s_wdat, s_rdat;
  logic [3:0]   s_sel;
  logic         s_we, s_cyc, s_stb, s_ack, s_err, s_rty;
  logic [2:0]   s_cti;
  logic [1:0]   s_bte;
  logic [2:0]   grant;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign m_stb  = m_cyc;
  assign m_cti  = {3'b000, 3'b000, cti0};
  assign m_adr  = {32'h0000_2000, 32'h0000_0100, 32'h0000_1000};
  assign m_wdat = {32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0};
  assign m_sel  = {4'hC, 4'h3, 4'hF};
  assign m_we   = 3'b100;
  assign m_bte  = '0;

  wb_rr_arbiter #(.NUM_MASTERS(N), .AW(32), .DW(32), .TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m_adr_i(m_adr), .m_dat_i(m_wdat), .m_sel_i(m_sel), .m_we_i(m_we),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_cti_i(m_cti), .m_bte_i(m_bte),
    .m_dat_o(m_rdat), .m_ack_o(m_ack), .m_err_o(m_err), .m_rty_o(m_rty),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_we_o(s_we),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_cti_o(s_cti), .s_bte_o(s_bte),
    .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(grant)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  cyc;
    logic [2:0]  cti0;
    logic [2:0]  rsp;
    logic [31:0] sdat;
    logic [2:0]  e_grant;
    logic        e_scyc;
    logic [2:0]  e_ack;
    logic [2:0]  e_err;
    logic [2:0]  e_rty;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [2:0] c, logic [2:0] t, logic [2:0] rsp, logic [31:0] d,
                              logic [2:0] g, logic sc, logic [2:0] a, logic [2:0] e, logic [2:0] y);
    vec_t v;
    v.rst = r; v.cyc = c; v.cti0 = t; v.rsp = rsp; v.sdat = d;
    v.e_grant = g; v.e_scyc = sc; v.e_ack = a; v.e_err = e; v.e_rty = y;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; m_cyc = '0; cti0 = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_rdat = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_vec(int i, vec_t v);
    logic [31:0] e_adr, e_wdat, e_rdat;
    logic [3:0]  e_sel;
    logic        e_we;
    logic [2:0]  e_cti;
    e_adr = '0; e_wdat = '0; e_rdat = '0; e_sel = '0; e_we = 1'b0; e_cti = '0;
    case (v.e_grant)
      3'b001: begin e_adr = 32'h1000; e_wdat = 32'hA0A0_A0A0; e_sel = 4'hF; e_cti = v.cti0; e_rdat = v.sdat; end
      3'b010: begin e_adr = 32'h0100; e_wdat = 32'hB1B1_B1B1; e_sel = 4'h3; e_rdat = v.sdat; end
      3'b100: begin e_adr = 32'h2000; e_wdat = 32'hC2C2_C2C2; e_sel = 4'hC; e_we = 1'b1; e_rdat = v.sdat; end
      default: ;
    endcase
    chk($sformatf("v%0d grant", i), 32'(grant), 32'(v.e_grant));
    chk($sformatf("v%0d s_cyc", i), 32'(s_cyc), 32'(v.e_scyc));
    chk($sformatf("v%0d s_stb", i), 32'(s_stb), 32'(v.e_scyc));
    chk($sformatf("v%0d m_ack", i), 32'(m_ack), 32'(v.e_ack));
    chk($sformatf("v%0d m_err", i), 32'(m_err), 32'(v.e_err));
    chk($sformatf("v%0d m_rty", i), 32'(m_rty), 32'(v.e_rty));
    chk($sformatf("v%0d m_dat", i), m_rdat, e_rdat);
    chk($sformatf("v%0d s_adr", i), s_adr, e_adr);
    chk($sformatf("v%0d s_dat", i), s_wdat, e_wdat);
    chk($sformatf("v%0d s_ctl", i), {23'd0, s_sel, s_we, s_cti, s_bte}, {23'd0, e_sel, e_we, e_cti, 2'b00});
  endtask

  initial begin
    // Single read by master 1, acked on the third bus cycle.
    vecs.push_back(mk(1'b1, 3'b010, 3'b000, NO, 32'h0,        3'b000, 1'b0, NO, NO, NO));
    vecs.push_back(mk(1'b0, 3'b010, 3'b000, NO, 32'h0,        3'b010, 1'b1, NO, NO, NO));
    vecs.push_back(mk(1'b0, 3'b010, 3'b000, NO, 32'h0,        3'b010, 1'b1, NO, NO, NO));
    vecs.push_back(mk(1'b0, 3'b010, 3'b000, A,  32'hDEADBEEF, 3'b010, 1'b1, 3'b010, NO, NO));
    vecs.push_back(mk(1'b0, 3'b000, 3'b000, NO, 32'h0,        3'b010, 1'b0, NO, NO, NO));
    vecs.push_back(mk(1'b0, 3'b000, 3'b000, NO, 32'h0,        3'b000, 1'b0, NO, NO, NO));
    // Three simultaneous requesters, master 0 re-requests right after its release.
    vecs.push_back(mk(1'b1, 3'b111, 3'b000, NO, 32'h0,        3'b000, 1'b0, NO, NO, NO));
    vecs.push_back(mk(1'b0, 3'b111, 3'b000, NO, 32'h0,        3'b001, 1'b1, NO, NO, NO));
    vecs.push_back(mk(1'b0, 3'b111, 3'b000, A,  32'h11111111, 3'b001, 1'b1, 3'b001, NO, NO));
    vecs.push_back(mk(1'b0, 3'b110, 3'b000, NO, 32'h0,        3'b001, 1'b0, NO, NO, NO));
    vecs.push_back(mk(1'b0, 3'b111, 3'b000, NO, 32'h0,        3'b000, 1'b0, NO, NO, NO));
    vecs.push_back(mk(1'b0, 3'b111, 3'b000, NO, 32'h0,        3'b010, 1'b1, NO, NO, NO));
    vecs.push_back(mk(1'b0, 3'b111, 3'b000, A,  32'h22222222, 3'b010, 1'b1, 3'b010, NO, NO));
    vecs.push_back(mk(1'b0, 3'b101, 3'b000, NO, 32'h0,        3'b010, 1'b0, NO, NO, NO));
    vecs.push_back(mk(1'b0, 3'b101, 3'b000, NO, 32'h0,        3'b000, 1'b0, NO, NO, NO));
    vecs.push_back(mk(1'b0, 3'b101, 3'b000, NO, 32'h0,        3'b100, 1'b1, NO, NO, NO));
    vecs.push_back(mk(1'b0, 3'b101, 3'b000, A,  32'h33333333, 3'b100, 1'b1, 3'b100, NO, NO));
    vecs.push_back(mk(1'b0, 3'b001, 3'b000, NO, 32'h0,        3'b100, 1'b0, NO, NO, NO));
    vecs.push_back(mk(1'b0, 3'b001, 3'b000, NO, 32'h0,        3'b000, 1'b0, NO, NO, NO));
    vecs.push_back(mk(1'b0, 3'b001, 3'b000, NO, 32'h0,        3'b001, 1'b1, NO, NO, NO));
    vecs.push_back(mk(1'b0, 3'b001, 3'b000, A,  32'h44444444, 3'b001, 1'b1, 3'b001, NO, NO));
    vecs.push_back(mk(1'b0, 3'b000, 3'b000, NO, 32'h0,        3'b001, 1'b0, NO, NO, NO));
    vecs.push_back(mk(1'b0, 3'b000, 3'b000, NO, 32'h0,        3'b000, 1'b0, NO, NO, NO));
    // Four-beat incrementing burst by master 0 while master 2 waits.
    vecs.push_back(mk(1'b1, 3'b101, 3'b010, NO, 32'h0,        3'b000, 1'b0, NO, NO, NO));
    vecs.push_back(mk(1'b0, 3'b101, 3'b010, NO, 32'h0,        3'b001, 1'b1, NO, NO, NO));
    vecs.push_back(mk(1'b0, 3'b101, 3'b010, A,  32'hA0000000, 3'b001, 1'b1, 3'b001, NO, NO));
    vecs.push_back(mk(1'b0, 3'b101, 3'b010, A,  32'hA0000001, 3'b001, 1'b1, 3'b001, NO, NO));
    vecs.push_back(mk(1'b0, 3'b101, 3'b010, A,  32'hA0000002, 3'b001, 1'b1, 3'b001, NO, NO));
    vecs.push_back(mk(1'b0, 3'b101, 3'b111, A,  32'hA0000003, 3'b001, 1'b1, 3'b001, NO, NO));
    vecs.push_back(mk(1'b0, 3'b100, 3'b000, NO, 32'h0,        3'b001, 1'b0, NO, NO, NO));
    vecs.push_back(mk(1'b0, 3'b100, 3'b000, NO, 32'h0,        3'b000, 1'b0, NO, NO, NO));
    vecs.push_back(mk(1'b0, 3'b100, 3'b000, NO, 32'h0,        3'b100, 1'b1, NO, NO, NO));
    vecs.push_back(mk(1'b0, 3'b100, 3'b000, A,  32'h0BADF00D, 3'b100, 1'b1, 3'b100, NO, NO));
    vecs.push_back(mk(1'b0, 3'b000, 3'b000, NO, 32'h0,        3'b100, 1'b0, NO, NO, NO));
    // Master 1 holds CYC while master 0 owns; err/rty reach master 0 only, nothing while idle.
    vecs.push_back(mk(1'b1, 3'b011, 3'b000, NO, 32'h0,        3'b000, 1'b0, NO, NO, NO));
    vecs.push_back(mk(1'b0, 3'b011, 3'b000, NO, 32'h0,        3'b001, 1'b1, NO, NO, NO));
    vecs.push_back(mk(1'b0, 3'b011, 3'b000, E,  32'h0,        3'b001, 1'b1, NO, 3'b001, NO));
    vecs.push_back(mk(1'b0, 3'b011, 3'b000, R,  32'h0,        3'b001, 1'b1, NO, NO, 3'b001));
    vecs.push_back(mk(1'b0, 3'b010, 3'b000, NO, 32'h0,        3'b001, 1'b0, NO, NO, NO));
    vecs.push_back(mk(1'b0, 3'b010, 3'b000, E,  32'h0,        3'b000, 1'b0, NO, NO, NO));
    vecs.push_back(mk(1'b0, 3'b010, 3'b000, NO, 32'h0,        3'b010, 1'b1, NO, NO, NO));
    vecs.push_back(mk(1'b0, 3'b000, 3'b000, NO, 32'h0,        3'b010, 1'b0, NO, NO, NO));

    rst_n = 1'b1; m_cyc = '0; cti0 = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_rdat = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst grant", 32'(grant), 32'd0);
    chk("rst s_cyc", 32'(s_cyc), 32'd0);
    chk("rst s_adr", s_adr, 32'd0);
    chk("rst m_resp", 32'({m_ack, m_err, m_rty}), 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      else @(negedge clk);
      m_cyc = vecs[i].cyc; cti0 = vecs[i].cti0; s_rdat = vecs[i].sdat;
      s_ack = vecs[i].rsp[0]; s_err = vecs[i].rsp[1]; s_rty = vecs[i].rsp[2];
      #1;
      check_vec(i, vecs[i]);
    end

    // Asynchronous reset in the middle of master 1's burst, after master 0 owned last.
    do_reset();
    m_cyc = 3'b001;
    @(negedge clk); s_ack = 1'b1;
    @(negedge clk); m_cyc = 3'b000; s_ack = 1'b0;
    @(negedge clk); m_cyc = 3'b010; cti0 = 3'b000;
    @(negedge clk); #1;
    chk("arst owner1", 32'(grant), 32'b010);
    s_ack = 1'b1; s_rdat = 32'h5555_5555;
    #1;
    chk("arst ack1", 32'(m_ack), 32'b010);
    m_cyc = 3'b011;
    #1 rst_n = 1'b0;
    #1;
    chk("arst grant", 32'(grant), 32'd0);
    chk("arst s_cyc", 32'({s_cyc, s_stb}), 32'd0);
    chk("arst s_req", s_adr | s_wdat | 32'({s_sel, s_we, s_cti, s_bte}), 32'd0);
    chk("arst m_resp", 32'({m_ack, m_err, m_rty}), 32'd0);
    chk("arst m_dat", m_rdat, 32'd0);
    @(negedge clk); rst_n = 1'b1; s_ack = 1'b0; s_rdat = '0;
    #1;
    chk("arst idle", 32'(grant), 32'd0);
    @(negedge clk); #1;
    chk("arst m0 first", 32'(grant), 32'b001);

`ifdef WB_ARB_TIMEOUT_EN
    // Slave never answers: error lands 9 cycles after the grant with CYC withdrawn.
    do_reset();
    m_cyc = 3'b101;
    @(negedge clk); #1;
    chk("wdog grant", 32'(grant), 32'b001);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #1;
      chk($sformatf("wdog wait%0d err", k), 32'(m_err), 32'd0);
      chk($sformatf("wdog wait%0d cyc", k), 32'(s_cyc), 32'd1);
    end
    @(negedge clk); #1;
    chk("wdog err pulse", 32'(m_err), 32'b001);
    chk("wdog cyc drop", 32'({s_cyc, s_stb}), 32'd0);
    s_ack = 1'b1; m_cyc = 3'b100;
    #1;
    chk("wdog late ack", 32'(m_ack), 32'd0);
    @(negedge clk); #1;
    chk("wdog err once", 32'(m_err), 32'd0);
    chk("wdog idle", 32'(grant), 32'd0);
    s_ack = 1'b0;
    @(negedge clk); #1;
    chk("wdog next", 32'(grant), 32'b100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Round-robin Wishbone B3 arbiter that shares one 32-bit slave port between up to NUM_MASTERS masters, e.g. CPU instruction bus, CPU data bus and the debug-interface master contending for the boot ROM or the UART data-resize bridge. Ownership is held for the whole cycle (CYC high), so registered-feedback bursts are never split. An optional watchdog aborts a stalled slave with an error so no master hangs indefinitely.

## Interface
- NUM_MASTERS, 3: number of requesting masters, 2..8
- AW, 32: address width
- DW, 32: data width; SEL width is DW/8
- TIMEOUT_CYCLES, 255: stall limit for the watchdog, 1..65535
- wb_clk_i  in  1  clock; all logic is on the rising edge
- wb_rst_n_i  in  1  reset, asynchronous assert, active-low
- m_adr_i / m_dat_i / m_sel_i  in  NUM_MASTERS×AW / ×DW / ×DW/8  packed per-master request fields, master k in slice k
- m_we_i, m_cyc_i, m_stb_i  in  NUM_MASTERS each  per-master controls
- m_cti_i / m_bte_i  in  NUM_MASTERS×3 / ×2  per-master burst type
- m_dat_o  out  DW  shared read data, broadcast to all masters
- m_ack_o, m_err_o, m_rty_o  out  NUM_MASTERS each  per-master responses
- s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o  out  AW, DW, DW/8, 1, 1, 1, 3, 2  slave request
- s_dat_i, s_ack_i, s_err_i, s_rty_i  in  DW, 1, 1, 1  slave response
- grant_o  out  NUM_MASTERS  one-hot current owner, 0 when idle (debug/visibility)

## Operation
- States: IDLE, BUSY, ABORT.
- IDLE: if any m_cyc_i is high, select the first requester scanning from last+1 upward with wrap-around. Load grant and go to BUSY.
- BUSY: the slave request outputs are a combinational mux of the granted master. s_ack_i, s_err_i and s_rty_i are routed only to that master. All other masters get ack, err and rty = 0.
- BUSY → IDLE when the granted master's m_cyc_i is low. last is set to the owner index and grant is cleared.
- In IDLE, all s_* request outputs are 0, including adr, dat and sel. grant_o = 0.
- Requests from non-granted masters are ignored. Their CYC may stay high indefinitely with no side effect.
- Arithmetic: the pointer is modulo NUM_MASTERS. Indices ≥ NUM_MASTERS are never granted.
- Reset values: state = IDLE, grant = 0, last = NUM_MASTERS−1 (master 0 wins first), watchdog count = 0. All outputs are 0.
- Reset mid-transaction drops s_cyc_o immediately, with no response to the master.

## Timing
- Arbitration latency: m_cyc_i seen in cycle N gives s_cyc_o high in cycle N+1.
- Slave response to master response: 0 cycles, combinational.
- Release: owner CYC low in cycle N means IDLE in N+1, and a new grant in N+2. There is one dead cycle between owners, for bus turnaround.
- Simultaneous requests: resolved purely by the round-robin pointer.
- The owner requesting again immediately after release has the lowest priority if others are waiting.
- A burst (cti 001/010, ending on 111) completes under one grant regardless of competing requests.

## Configuration
- WB_ARB_TIMEOUT_EN defined:
  - A 16-bit counter increments each BUSY cycle with s_stb_o=1 and no ack, err or rty.
  - The counter clears on any response and on entering BUSY.
  - When the count reaches TIMEOUT_CYCLES, go to ABORT.
  - ABORT: s_cyc_o and s_stb_o are 0, the owner gets m_err_o=1 for exactly one cycle, and the arbiter waits for the owner's CYC to go low before going to IDLE.
  - Late slave responses during ABORT are discarded.
- WB_ARB_TIMEOUT_EN undefined: no counter and no ABORT state. BUSY waits indefinitely.

## Test plan
- Single master 1 read at 0x0000_0100, slave acks after 2 cycles with 0xDEADBEEF → s_cyc_o high 1 cycle after m_cyc_i[1]; m_ack_o=3'b010 for one cycle; m_dat_o=0xDEADBEEF.
- Masters 0, 1, 2 all assert CYC in the same cycle, each doing one single read → grant sequence 001, 010, 100 with one idle cycle between grants. Master 0 re-requests immediately and is served after master 2.
- Master 0 runs a 4-beat incrementing burst (cti 010,010,010,111) while master 2 requests → all 4 acks go to master 0 before grant_o=100. m_ack_o[2] stays 0 throughout.
- WB_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, slave never acks → m_err_o pulses for exactly 1 cycle, 9 cycles after the grant, with s_cyc_o=0 from that cycle. After the owner drops CYC, the next master is granted.
- wb_rst_n_i pulsed low mid-burst → all outputs 0 asynchronously. After release, master 0 has priority over master 1 when both request.
- Non-granted master 1 holds CYC/STB while master 0 owns the bus and the slave asserts err → only m_err_o[0] rises. m_ack_o, m_err_o and m_rty_o for master 1 stay 0.
